// File: rtl/reg_file_cc.sv
// Parametrised LC-3 register file with link write port, optional bypass,
// one-hot condition codes and the BEN latch.
module reg_file_cc #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Bus,
    input  logic             LD_REG,
    input  logic [AW-1:0]    DR,
    input  logic             LNK_WE,
    input  logic [AW-1:0]    LNK_DR,
    input  logic [WIDTH-1:0] LNK_DATA,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    output logic [WIDTH-1:0] SR1OUT,
    output logic [WIDTH-1:0] SR2OUT,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [2:0]       NZP_mask,
    output logic [2:0]       CC,
    output logic             BEN
);

    localparam logic [AW:0] NR = (AW+1)'(NREGS);
    localparam logic BYP = (BYPASS != 0);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] sr1_raw;
    logic [WIDTH-1:0] sr2_raw;
    logic             sr1_ok;
    logic             sr2_ok;
    logic             sr1_pri;
    logic             sr1_lnk;
    logic             sr2_pri;
    logic             sr2_lnk;
    logic [2:0]       cc_q;
    logic [2:0]       cc_d;
    logic             ben_q;

    // Out-of-range addresses never match an index, so they write nothing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (LD_REG && DR == AW'(i))
                    regs[i] <= Bus;
                else if (LNK_WE && LNK_DR == AW'(i))
                    regs[i] <= LNK_DATA;
            end
        end
    end

    always_comb begin
        sr1_raw = '0;
        sr2_raw = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (SR1 == AW'(i)) sr1_raw = regs[i];
            if (SR2 == AW'(i)) sr2_raw = regs[i];
        end
    end

    assign sr1_ok = {1'b0, SR1} < NR;
    assign sr2_ok = {1'b0, SR2} < NR;

    assign sr1_pri = BYP && sr1_ok && LD_REG && DR == SR1;
    assign sr1_lnk = BYP && sr1_ok && LNK_WE && LNK_DR == SR1;
    assign sr2_pri = BYP && sr2_ok && LD_REG && DR == SR2;
    assign sr2_lnk = BYP && sr2_ok && LNK_WE && LNK_DR == SR2;

    // Bus has priority over link data, matching the write collision rule.
    assign SR1OUT = sr1_pri ? Bus : sr1_lnk ? LNK_DATA : sr1_raw;
    assign SR2OUT = sr2_pri ? Bus : sr2_lnk ? LNK_DATA : sr2_raw;

    always_comb begin
        if (Bus[WIDTH-1])
            cc_d = 3'b100;
        else if (Bus == '0)
            cc_d = 3'b010;
        else
            cc_d = 3'b001;
    end

    // BEN samples the pre-edge CC, so a same-cycle LD_CC is seen next cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cc_q  <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (LD_CC)  cc_q  <= cc_d;
            if (LD_BEN) ben_q <= |(NZP_mask & cc_q);
        end
    end

    assign CC  = cc_q;
    assign BEN = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
// Self-checking bench for reg_file_cc: 8x16 with and without bypass,
// plus a 6x32 instance for address-range and width boundaries.
module tb_reg_file_cc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus = '0;
    logic        ld_reg = 0, lnk_we = 0, ld_cc = 0, ld_ben = 0;
    logic [2:0]  dr = '0, lnk_dr = '0, sr1 = '0, sr2 = '0, nzp = '0;
    logic [15:0] lnk_data = '0;
    logic [15:0] a_sr1, a_sr2, b_sr1, b_sr2;
    logic [2:0]  a_cc, b_cc;
    logic        a_ben, b_ben;

    logic [31:0] c_bus = '0, c_lnk_data = '0;
    logic        c_ld_reg = 0, c_lnk_we = 0, c_ld_cc = 0, c_ld_ben = 0;
    logic [2:0]  c_dr = '0, c_lnk_dr = '0, c_sr1 = '0, c_sr2 = '0;
    logic [2:0]  c_nzp = '0;
    logic [31:0] c_sr1o, c_sr2o;
    logic [2:0]  c_cc;
    logic        c_ben;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk = 0;

    always #5 clk = ~clk;

    reg_file_cc #(.WIDTH(16), .NREGS(8), .BYPASS(1)) dut_a (
        .Clk(clk), .Reset(rst), .Bus(bus), .LD_REG(ld_reg), .DR(dr),
        .LNK_WE(lnk_we), .LNK_DR(lnk_dr), .LNK_DATA(lnk_data),
        .SR1(sr1), .SR2(sr2), .SR1OUT(a_sr1), .SR2OUT(a_sr2),
        .LD_CC(ld_cc), .LD_BEN(ld_ben), .NZP_mask(nzp),
        .CC(a_cc), .BEN(a_ben));

    reg_file_cc #(.WIDTH(16), .NREGS(8), .BYPASS(0)) dut_b (
        .Clk(clk), .Reset(rst), .Bus(bus), .LD_REG(ld_reg), .DR(dr),
        .LNK_WE(lnk_we), .LNK_DR(lnk_dr), .LNK_DATA(lnk_data),
        .SR1(sr1), .SR2(sr2), .SR1OUT(b_sr1), .SR2OUT(b_sr2),
        .LD_CC(ld_cc), .LD_BEN(ld_ben), .NZP_mask(nzp),
        .CC(b_cc), .BEN(b_ben));

    reg_file_cc #(.WIDTH(32), .NREGS(6), .BYPASS(1)) dut_c (
        .Clk(clk), .Reset(rst), .Bus(c_bus), .LD_REG(c_ld_reg),
        .DR(c_dr), .LNK_WE(c_lnk_we), .LNK_DR(c_lnk_dr),
        .LNK_DATA(c_lnk_data), .SR1(c_sr1), .SR2(c_sr2),
        .SR1OUT(c_sr1o), .SR2OUT(c_sr2o), .LD_CC(c_ld_cc),
        .LD_BEN(c_ld_ben), .NZP_mask(c_nzp), .CC(c_cc), .BEN(c_ben));

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural model of the 8x16 file, shared by both 8x16 DUTs.
    logic [15:0] m_regs [8];
    logic [2:0]  m_cc;
    logic        m_ben;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] <= '0;
            m_cc  <= 3'b010;
            m_ben <= 1'b0;
        end else begin
            if (ld_ben) m_ben <= (nzp & m_cc) != 3'b000;
            if (ld_cc) begin
                if ($signed(bus) < 0)  m_cc <= 3'b100;
                else if (bus == 0)     m_cc <= 3'b010;
                else                   m_cc <= 3'b001;
            end
            if (lnk_we) m_regs[lnk_dr] <= lnk_data;
            if (ld_reg) m_regs[dr] <= bus;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [2:0] a,
                                           input bit byp);
        if (byp && ld_reg && dr == a) return bus;
        if (byp && lnk_we && lnk_dr == a) return lnk_data;
        return m_regs[a];
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            check("a_sr1", 32'(a_sr1), 32'(exp_rd(sr1, 1)));
            check("a_sr2", 32'(a_sr2), 32'(exp_rd(sr2, 1)));
            check("b_sr1", 32'(b_sr1), 32'(exp_rd(sr1, 0)));
            check("b_sr2", 32'(b_sr2), 32'(exp_rd(sr2, 0)));
            check("a_cc", 32'(a_cc), 32'(m_cc));
            check("b_cc", 32'(b_cc), 32'(m_cc));
            check("a_ben", 32'(a_ben), 32'(m_ben));
            check("b_ben", 32'(b_ben), 32'(m_ben));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ld_reg = 0; lnk_we = 0; ld_cc = 0; ld_ben = 0;
        c_ld_reg = 0; c_lnk_we = 0; c_ld_cc = 0; c_ld_ben = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        step();
        chk = 1;
        step();
        rst = 0;

        // Reset contents on every address and both ports.
        for (int a = 0; a < 8; a++) begin
            step();
            sr1 = 3'(a);
            sr2 = 3'(7 - a);
            settle();
            check("rst_a_sr1", 32'(a_sr1), 32'h0);
            check("rst_b_sr2", 32'(b_sr2), 32'h0);
        end
        check("rst_cc", 32'(a_cc), 32'(3'b010));
        check("rst_ben", 32'(a_ben), 32'h0);

        // Same-cycle bypass vs. stored-only read.
        step();
        ld_reg = 1; dr = 3; bus = 16'h8001; sr1 = 3; sr2 = 3;
        settle();
        check("byp_sr1", 32'(a_sr1), 32'h8001);
        check("byp_sr2", 32'(a_sr2), 32'h8001);
        check("nobyp_sr1", 32'(b_sr1), 32'h0000);
        step();
        settle();
        check("nobyp_after", 32'(b_sr1), 32'h8001);

        // Collision: Bus wins over link data.
        step();
        ld_reg = 1; dr = 7; bus = 16'h1111;
        lnk_we = 1; lnk_dr = 7; lnk_data = 16'h2222;
        sr1 = 7; sr2 = 7;
        settle();
        check("coll_byp", 32'(a_sr1), 32'h1111);
        step();
        settle();
        check("coll_r7", 32'(b_sr1), 32'h1111);

        // Dual write to distinct addresses.
        step();
        ld_reg = 1; dr = 7; bus = 16'h1111;
        lnk_we = 1; lnk_dr = 6; lnk_data = 16'h2222;
        sr1 = 7; sr2 = 6;
        settle();
        check("dual_lnk_byp", 32'(a_sr2), 32'h2222);
        step();
        settle();
        check("dual_r7", 32'(b_sr1), 32'h1111);
        check("dual_r6", 32'(b_sr2), 32'h2222);

        // Link-only write and a non-matching primary write.
        step();
        lnk_we = 1; lnk_dr = 1; lnk_data = 16'h0ABC;
        ld_reg = 1; dr = 0; bus = 16'h7FFF; sr1 = 1; sr2 = 0;
        settle();
        check("lnk_only_byp", 32'(a_sr1), 32'h0ABC);
        step();
        sr1 = 3;
        settle();

        // Condition codes and BEN.
        step();
        ld_cc = 1; bus = 16'hFFFF;
        step();
        ld_cc = 1; bus = 16'h0000;
        settle();
        check("cc_neg", 32'(a_cc), 32'(3'b100));
        step();
        ld_cc = 1; bus = 16'h0005;
        settle();
        check("cc_zero", 32'(a_cc), 32'(3'b010));
        step();
        ld_ben = 1; nzp = 3'b001;
        settle();
        check("cc_pos", 32'(a_cc), 32'(3'b001));
        step();
        ld_ben = 1; nzp = 3'b110;
        settle();
        check("ben_p", 32'(a_ben), 32'h1);
        step();
        settle();
        check("ben_nz", 32'(a_ben), 32'h0);

        // LD_CC and LD_BEN together: BEN uses the old CC.
        step();
        ld_cc = 1; bus = 16'h8000; ld_ben = 1; nzp = 3'b100;
        step();
        ld_ben = 1; nzp = 3'b100;
        settle();
        check("ben_oldcc", 32'(a_ben), 32'h0);
        check("cc_8000", 32'(a_cc), 32'(3'b100));
        step();
        settle();
        check("ben_newcc", 32'(a_ben), 32'h1);

        // 6x32 instance: out-of-range writes and reads.
        step();
        c_ld_reg = 1; c_dr = 6; c_bus = 32'hDEADBEEF;
        c_lnk_we = 1; c_lnk_dr = 7; c_lnk_data = 32'hFFFFFFFF;
        c_sr1 = 6; c_sr2 = 7;
        settle();
        check("c_oob_byp1", c_sr1o, 32'h0);
        check("c_oob_byp2", c_sr2o, 32'h0);
        for (int a = 0; a < 8; a++) begin
            step();
            c_sr1 = 3'(a);
            c_sr2 = 3'(7 - a);
            settle();
            check("c_noalias1", c_sr1o, 32'h0);
            check("c_noalias2", c_sr2o, 32'h0);
        end
        step();
        c_ld_reg = 1; c_dr = 5; c_bus = 32'h12345678;
        c_lnk_we = 1; c_lnk_dr = 2; c_lnk_data = 32'h55AA55AA;
        c_sr1 = 5; c_sr2 = 2;
        settle();
        check("c_byp_r5", c_sr1o, 32'h12345678);
        check("c_byp_r2", c_sr2o, 32'h55AA55AA);
        step();
        settle();
        check("c_r5", c_sr1o, 32'h12345678);
        check("c_r2", c_sr2o, 32'h55AA55AA);
        step();
        c_ld_cc = 1; c_bus = 32'h80000000;
        step();
        c_ld_cc = 1; c_bus = 32'h00008000;
        settle();
        check("c_cc_neg", 32'(c_cc), 32'(3'b100));
        step();
        settle();
        check("c_cc_pos", 32'(c_cc), 32'(3'b001));

        // Reset dominates writes, LD_CC and LD_BEN in the same cycle.
        step();
        rst = 1;
        ld_reg = 1; dr = 2; bus = 16'hBEEF;
        ld_cc = 1; ld_ben = 1; nzp = 3'b111;
        c_ld_reg = 1; c_dr = 2; c_bus = 32'h11111111; c_ld_cc = 1;
        step();
        rst = 0;
        sr1 = 2; sr2 = 7; c_sr1 = 2; c_sr2 = 5;
        settle();
        check("rst2_a_r2", 32'(a_sr1), 32'h0);
        check("rst2_b_r2", 32'(b_sr1), 32'h0);
        check("rst2_a_r7", 32'(a_sr2), 32'h0);
        check("rst2_cc", 32'(a_cc), 32'(3'b010));
        check("rst2_ben", 32'(a_ben), 32'h0);
        check("rst2_c_r2", c_sr1o, 32'h0);
        check("rst2_c_r5", c_sr2o, 32'h0);
        check("rst2_c_cc", 32'(c_cc), 32'(3'b010));
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_cc.md
Name: reg_file_cc

Overview:
- Parametrised successor to the 8x16 LC-3 register file plus nzp/ben logic, which until now were separate datapath blocks.
- Provides an NREGS x WIDTH register array with two combinational read ports, a primary (bus) write port and a secondary (link) write port for JSR/TRAP R7 saves.
- Includes optional write-to-read bypass, the one-hot condition-code register and the BEN latch.
- Sits in the datapath between BUS, the SR1/SR2/DR muxes and the ALU.

Parameters:
- WIDTH, 16, data width of registers, bus and read ports (>=2).
- NREGS, 8, number of architectural registers (>=2, need not be a power of two).
- AW, $clog2(NREGS), register address width; derived, not overridden.
- BYPASS, 1, 1 = a same-cycle write is forwarded to read ports; 0 = reads always return stored contents.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Bus  input  WIDTH  primary write data and CC source.
- LD_REG  input  1  primary write enable.
- DR  input  AW  primary write address.
- LNK_WE  input  1  secondary (link) write enable.
- LNK_DR  input  AW  secondary write address.
- LNK_DATA  input  WIDTH  secondary write data.
- SR1  input  AW  read port 1 address.
- SR2  input  AW  read port 2 address.
- SR1OUT  output  WIDTH  read port 1 data.
- SR2OUT  output  WIDTH  read port 2 data.
- LD_CC  input  1  load condition codes from Bus.
- LD_BEN  input  1  load BEN.
- NZP_mask  input  3  branch mask {n,z,p} (IR[11:9]).
- CC  output  3  registered condition codes {N,Z,P}.
- BEN  output  1  registered branch enable.

Behaviour:
- Reset is synchronous, active-high, on Clk rising edge.
  - Reset value of every register is 0; CC = 3'b010 (Z); BEN = 0.
  - Reset dominates every write, LD_CC and LD_BEN in the same cycle.
  - No partial state survives a reset asserted mid-operation.
- Writes:
  - On the rising edge, if LD_REG, reg[DR] <= Bus.
  - If LNK_WE, reg[LNK_DR] <= LNK_DATA.
  - Both may fire in one cycle to different addresses; both take effect.
  - Collision (LD_REG && LNK_WE && DR == LNK_DR): primary (Bus) wins; link data is dropped.
- Address range:
  - Any write address >= NREGS is ignored (no aliasing).
  - Any read address >= NREGS returns 0.
- Reads are combinational, zero latency.
  - BYPASS = 0: SRxOUT = reg[SRx] as stored.
  - BYPASS = 1: if a write to SRx is enabled this cycle, SRxOUT shows the winning write data (same priority as the collision rule); otherwise stored contents.
  - Both read ports may address the same register; both bypass independently.
- Condition codes (LD_CC, registered, one cycle):
  - CC <= 3'b100 if Bus[WIDTH-1] = 1.
  - CC <= 3'b010 if Bus == 0.
  - CC <= 3'b001 otherwise.
  - CC is always exactly one-hot; without LD_CC, CC holds.
- BEN (LD_BEN, registered): BEN <= |(NZP_mask & CC), using the CC value before this edge.
  - With LD_CC and LD_BEN in the same cycle, BEN sees the old CC; the new CC is visible to BEN from the next cycle.
  - Without LD_BEN, BEN holds.
- No other state. Outputs never go X after reset; read ports are driven even with no write.

Test Plan:
1. Reset, then read all 8 registers -> SR1OUT = SR2OUT = 16'h0000 for every address; CC = 3'b010; BEN = 0.
2. LD_REG, DR = 3, Bus = 16'h8001; SR1 = 3 (BYPASS = 1) -> SR1OUT = 16'h8001 in the same cycle. With BYPASS = 0, SR1OUT = 16'h0000 until after the edge, then 16'h8001.
3. Same cycle: LD_REG DR = 7 Bus = 16'h1111, LNK_WE LNK_DR = 7 LNK_DATA = 16'h2222 -> R7 = 16'h1111. Repeat with LNK_DR = 6 -> R7 = 16'h1111 and R6 = 16'h2222.
4. LD_CC with Bus = 16'hFFFF, 16'h0000, 16'h0005 on successive cycles -> CC = 100, 010, 001. Then LD_BEN, NZP_mask = 3'b001 -> BEN = 1; NZP_mask = 3'b110 -> BEN = 0.
5. From CC = 001: LD_CC (Bus = 16'h8000) and LD_BEN (mask = 3'b100) together -> BEN = 0 and CC = 100. Re-issue LD_BEN next cycle -> BEN = 1.
6. NREGS = 6, WIDTH = 32: write 32'hDEADBEEF to addr 6 -> no register changes and a read of addr 6 = 0. Assert Reset together with LD_REG to R2 -> R2 = 0, CC = 010.
